// File: rtl/stream_driver_pkg.sv
// Shared types and helpers for the stream test driver: FSM encoding,
// backpressure pattern length and the checksum rotate.
package stream_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } drv_state_e;

  localparam int BP_LEN = 8;
  localparam int BP_W   = $clog2(BP_LEN);
  localparam int MAX_DW = 256;

  // Rotate left by one within the low w bits; v must be zero above bit w-1.
  function automatic logic [MAX_DW-1:0] rotl1(input logic [MAX_DW-1:0] v,
                                              input int unsigned w);
    logic [MAX_DW-1:0] mask;
    mask = (w >= MAX_DW) ? '1 : ((MAX_DW'(1) << w) - MAX_DW'(1));
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/stream_sink_lane.sv
// One drained output channel: EOS flag, saturating element counter and
// rotate-XOR checksum.
module stream_sink_lane
  import stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  beat,
  input  logic                  eos,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  eos_seen,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] checksum
);

  logic                  eos_seen_q, eos_seen_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [MAX_DW-1:0]     csum_rot;

  always_comb begin
    csum_rot   = rotl1(MAX_DW'(csum_q), DATA_WIDTH);
    eos_seen_d = eos_seen_q;
    count_d    = count_q;
    csum_d     = csum_q;
    if (clear) begin
      eos_seen_d = 1'b0;
      count_d    = '0;
      csum_d     = '0;
    end else if (beat) begin
      if (eos) begin
        eos_seen_d = 1'b1;
      end else begin
        if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
        csum_d = csum_rot[DATA_WIDTH-1:0] ^ data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eos_seen_q <= 1'b0;
      count_q    <= '0;
      csum_q     <= '0;
    end else begin
      eos_seen_q <= eos_seen_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
    end
  end

  assign eos_seen = eos_seen_q;
  assign count    = count_q;
  assign checksum = csum_q;

endmodule

// File: rtl/stream_test_driver.sv
// Fires the DUT start token, drains NUM_OUT output streams under a
// backpressure pattern and reports done / timeout.
module stream_test_driver
  import stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_OUT    = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [7:0]                      bp_mask,
  output logic                            inCtrl_valid,
  input  logic                            inCtrl_ready,
  input  logic                            outCtrl_valid,
  output logic                            outCtrl_ready,
  input  logic [NUM_OUT-1:0]              out_valid,
  output logic [NUM_OUT-1:0]              out_ready,
  input  logic [NUM_OUT*DATA_WIDTH-1:0]   out_data,
  input  logic [NUM_OUT-1:0]              out_eos,
  output logic [NUM_OUT*CNT_WIDTH-1:0]    elem_count,
  output logic [NUM_OUT*DATA_WIDTH-1:0]   checksum,
  output logic                            done,
  output logic                            error
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  drv_state_e        state_q, state_d;
  logic [BP_W-1:0]   bp_idx_q, bp_idx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              ctrl_seen_q, ctrl_seen_d;
  logic              error_q, error_d;
  logic              inctrl_valid_q, inctrl_valid_d;
  logic              outctrl_ready_q, outctrl_ready_d;
  logic              done_q, done_d;

  logic               clear;
  logic               run_ready;
  logic               in_beat, ctrl_beat, any_beat, all_eos, tmo_hit;
  logic [NUM_OUT-1:0] eos_seen, lane_beat;

  assign run_ready = (state_q == ST_RUN) ? bp_mask[bp_idx_q] : 1'b0;
  assign out_ready = ~eos_seen & {NUM_OUT{run_ready}};
  assign lane_beat = out_valid & out_ready;
  assign in_beat   = inctrl_valid_q & inCtrl_ready;
  assign ctrl_beat = outCtrl_valid & outctrl_ready_q;
  assign any_beat  = (|lane_beat) | ctrl_beat | in_beat;
  // EOS beats taken this cycle count towards completion right away.
  assign all_eos   = &(eos_seen | (lane_beat & out_eos));
  assign tmo_hit   = !any_beat && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    bp_idx_d    = bp_idx_q;
    tmo_d       = tmo_q;
    ctrl_seen_d = ctrl_seen_q;
    error_d     = error_q;
    clear       = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear       = 1'b1;
          state_d     = ST_FIRE;
          bp_idx_d    = '0;
          tmo_d       = '0;
          ctrl_seen_d = 1'b0;
          error_d     = 1'b0;
        end
      end
      ST_FIRE: begin
        tmo_d = any_beat ? '0 : tmo_q + TW'(1);
        if (in_beat) begin
          state_d = ST_RUN;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end
      end
      ST_RUN: begin
        bp_idx_d = bp_idx_q + BP_W'(1);
        tmo_d    = any_beat ? '0 : tmo_q + TW'(1);
        if (ctrl_beat) ctrl_seen_d = 1'b1;
        if (all_eos && (ctrl_seen_q || ctrl_beat)) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inctrl_valid_d  = (state_d == ST_FIRE);
    outctrl_ready_d = (state_d == ST_RUN) && !ctrl_seen_d;
    done_d          = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      bp_idx_q        <= '0;
      tmo_q           <= '0;
      ctrl_seen_q     <= 1'b0;
      error_q         <= 1'b0;
      inctrl_valid_q  <= 1'b0;
      outctrl_ready_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bp_idx_q        <= bp_idx_d;
      tmo_q           <= tmo_d;
      ctrl_seen_q     <= ctrl_seen_d;
      error_q         <= error_d;
      inctrl_valid_q  <= inctrl_valid_d;
      outctrl_ready_q <= outctrl_ready_d;
      done_q          <= done_d;
    end
  end

  assign inCtrl_valid  = inctrl_valid_q;
  assign outCtrl_ready = outctrl_ready_q;
  assign done          = done_q;
  assign error         = error_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
    stream_sink_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .beat    (lane_beat[g]),
      .eos     (out_eos[g]),
      .data    (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .eos_seen(eos_seen[g]),
      .count   (elem_count[g*CNT_WIDTH +: CNT_WIDTH]),
      .checksum(checksum[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_test_driver.sv
// Randomised and directed bench for stream_test_driver against a
// cycle-level behavioural model of the driver's rules.
module tb_stream_test_driver;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int CW = 4;
  localparam int TO = 16;
  localparam int MI = 0, MF = 1, MR = 2, MD = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      bp_mask = 8'h00;
  logic            inCtrl_valid;
  logic            inCtrl_ready = 1'b0;
  logic            outCtrl_valid = 1'b0;
  logic            outCtrl_ready;
  logic [N-1:0]    out_valid = '0;
  logic [N-1:0]    out_ready;
  logic [N*DW-1:0] out_data = '0;
  logic [N-1:0]    out_eos = '0;
  logic [N*CW-1:0] elem_count;
  logic [N*DW-1:0] checksum;
  logic            done, error;

  stream_test_driver #(
    .DATA_WIDTH(DW), .NUM_OUT(N), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bp_mask(bp_mask),
    .inCtrl_valid(inCtrl_valid), .inCtrl_ready(inCtrl_ready),
    .outCtrl_valid(outCtrl_valid), .outCtrl_ready(outCtrl_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eos(out_eos), .elem_count(elem_count), .checksum(checksum),
    .done(done), .error(error)
  );

  initial forever #5 clock = ~clock;

  // behavioural model
  int          ph, idle, slot, run_cycles;
  bit          m_eos[N];
  int          m_cnt[N];
  logic [DW-1:0] m_cs[N];
  bit          m_ctrl, m_err;

  // stimulus: per channel a list of payloads, EOS sent at index slen
  logic [DW-1:0] sdata[N][64];
  int          slen[N];
  int          sptr[N];
  bit          vhold[N];
  int          in_wait, ctrl_wait, tok_cnt, hi_cnt;
  bit          ctrl_pend, start_req, rand_start;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int next_ph);
    ph = next_ph; idle = 0; slot = 0; run_cycles = 0;
    m_ctrl = 0; m_err = 0;
    for (int i = 0; i < N; i++) begin
      m_eos[i] = 0; m_cnt[i] = 0; m_cs[i] = '0;
    end
  endtask

  task automatic drive_stim();
    start = 1'b0;
    if (start_req && (ph == MI || ph == MD)) begin
      start = 1'b1; start_req = 0;
    end else if (rand_start && (ph == MF || ph == MR) && $urandom_range(0, 15) == 0) begin
      start = 1'b1;
    end
    inCtrl_ready  = (in_wait == 0);
    outCtrl_valid = ctrl_pend && (ctrl_wait == 0);
    for (int i = 0; i < N; i++) begin
      if (!vhold[i] && sptr[i] <= slen[i] && $urandom_range(0, 3) != 0) vhold[i] = 1;
      out_valid[i] = vhold[i];
      out_eos[i]   = (sptr[i] == slen[i]);
      out_data[i*DW +: DW] = (sptr[i] < slen[i]) ? sdata[i][sptr[i]] : DW'($urandom);
    end
  endtask

  task automatic compare_all();
    chk("inCtrl_valid", inCtrl_valid, ph == MF);
    chk("outCtrl_ready", outCtrl_ready, (ph == MR) && !m_ctrl);
    chk("done", done, ph == MD);
    chk("error", error, m_err);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("out_ready[%0d]", i), out_ready[i],
          (ph == MR) && !m_eos[i] && bp_mask[slot]);
      chk($sformatf("elem_count[%0d]", i), elem_count[i*CW +: CW], m_cnt[i]);
      chk($sformatf("checksum[%0d]", i), checksum[i*DW +: DW], m_cs[i]);
    end
  endtask

  task automatic model_step();
    bit any_b, all_e;
    if (inCtrl_valid && inCtrl_ready) tok_cnt++;
    if (inCtrl_valid) hi_cnt++;
    if (ph == MI || ph == MD) begin
      if (start) model_clear(MF);
    end else if (ph == MF) begin
      if (in_wait > 0) in_wait--;
      if (inCtrl_ready) begin
        ph = MR; idle = 0;
      end else if (idle == TO - 1) begin
        ph = MD; m_err = 1;
      end else idle++;
    end else begin
      any_b = 0;
      if (ctrl_wait > 0) ctrl_wait--;
      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && !m_eos[i] && bp_mask[slot]) begin
          any_b = 1;
          if (out_eos[i]) m_eos[i] = 1;
          else begin
            if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
            m_cs[i] = {m_cs[i][DW-2:0], m_cs[i][DW-1]} ^ out_data[i*DW +: DW];
          end
          sptr[i]++; vhold[i] = 0;
        end
      end
      if (outCtrl_valid && !m_ctrl) begin
        any_b = 1; m_ctrl = 1; ctrl_pend = 0;
      end
      slot = (slot + 1) % 8;
      run_cycles++;
      all_e = 1;
      for (int i = 0; i < N; i++) if (!m_eos[i]) all_e = 0;
      if (all_e && m_ctrl) ph = MD;
      else if (any_b) idle = 0;
      else if (idle == TO - 1) begin ph = MD; m_err = 1; end
      else idle++;
    end
  endtask

  task automatic cycle();
    drive_stim();
    #1;
    compare_all();
    model_step();
    @(posedge clock); #1;
  endtask

  task automatic setup(input logic [7:0] bp, input int inw, input int ctw, input bit pend);
    bp_mask = bp; in_wait = inw; ctrl_wait = ctw; ctrl_pend = pend;
    tok_cnt = 0; hi_cnt = 0; start_req = 1;
    for (int i = 0; i < N; i++) begin sptr[i] = 0; vhold[i] = 0; end
  endtask

  task automatic fill_rand(input int ch, input int len);
    slen[ch] = len;
    for (int k = 0; k < len; k++) sdata[ch][k] = DW'($urandom);
  endtask

  task automatic load_s1();
    slen[0] = 3; sdata[0][0] = 16'h0001; sdata[0][1] = 16'h0002; sdata[0][2] = 16'h0003;
    slen[1] = 2; sdata[1][0] = 16'h8001; sdata[1][1] = 16'h0001;
  endtask

  task automatic run_to_done(input int budget, input string tag);
    int n = 0;
    cycle();
    while (ph != MD && n < budget) begin cycle(); n++; end
    checks++;
    if (ph != MD) begin
      failures++;
      $display("FAIL %s run did not complete within %0d cycles", tag, budget);
    end
    repeat (3) cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_inCtrl_valid"}, inCtrl_valid, 0);
    chk({tag, "_outCtrl_ready"}, outCtrl_ready, 0);
    chk({tag, "_out_ready"}, out_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_elem_count"}, elem_count, 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  task automatic chk_s1(input string tag);
    chk({tag, "_cnt0"}, elem_count[0 +: CW], 3);
    chk({tag, "_cs0"}, checksum[0 +: DW], 16'h0003);
    chk({tag, "_cnt1"}, elem_count[CW +: CW], 2);
    chk({tag, "_cs1"}, checksum[DW +: DW], 16'h0002);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_tokens"}, tok_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rand_start = 0; start_req = 0; ctrl_pend = 0; in_wait = 0; ctrl_wait = 0;
    for (int i = 0; i < N; i++) begin slen[i] = 0; sptr[i] = 1; vhold[i] = 0; end
    model_clear(MI);
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // basic run, unthrottled
    load_s1(); setup(8'hFF, 0, 2, 1);
    run_to_done(200, "basic");
    chk_s1("basic");

    // sparse backpressure and delayed inCtrl_ready
    load_s1(); setup(8'b0000_0101, 5, 3, 1);
    run_to_done(400, "bp05");
    chk_s1("bp05");
    chk("bp05_inCtrl_high_cycles", hi_cnt, 6);

    // channel 0 four elements, channel 1 EOS immediately
    fill_rand(0, 4); fill_rand(1, 0); setup(8'hFF, 1, 6, 1);
    run_to_done(200, "eos_early");
    chk("eos_early_cnt0", elem_count[0 +: CW], 4);
    chk("eos_early_cnt1", elem_count[CW +: CW], 0);

    // no readiness at all: timeout
    fill_rand(0, 3); fill_rand(1, 2); setup(8'h00, 0, 0, 0);
    run_to_done(200, "timeout");
    chk("timeout_done", done, 1);
    chk("timeout_error", error, 1);
    chk("timeout_run_cycles", run_cycles, 16);
    chk("timeout_cnt0", elem_count[0 +: CW], 0);

    // counter saturation
    fill_rand(0, 20); fill_rand(1, 1); setup(8'hFF, 0, 4, 1);
    run_to_done(400, "saturate");
    chk("saturate_cnt0", elem_count[0 +: CW], 4'hF);
    chk("saturate_cnt1", elem_count[CW +: CW], 1);

    // reset in the middle of a run, then a clean run
    fill_rand(0, 10); fill_rand(1, 10); setup(8'hFF, 0, 30, 1);
    repeat (8) cycle();
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    model_clear(MI);
    for (int i = 0; i < N; i++) vhold[i] = 0;
    out_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    load_s1(); setup(8'hFF, 0, 2, 1);
    run_to_done(200, "after_reset");
    chk_s1("after_reset");

    // randomised runs with stray start pulses
    rand_start = 1;
    for (int r = 0; r < 8; r++) begin
      fill_rand(0, $urandom_range(0, 12));
      fill_rand(1, $urandom_range(0, 12));
      setup(8'($urandom_range(0, 255)) | 8'h11, $urandom_range(0, 3), $urandom_range(0, 20), 1);
      run_to_done(1000, $sformatf("rand%0d", r));
      if (!m_err) begin
        chk($sformatf("rand%0d_cnt0", r), elem_count[0 +: CW], (slen[0] > 15) ? 15 : slen[0]);
        chk($sformatf("rand%0d_cnt1", r), elem_count[CW +: CW], (slen[1] > 15) ? 15 : slen[1]);
        chk($sformatf("rand%0d_tokens", r), tok_cnt, 1);
      end
    end
    rand_start = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
